// File: rtl/dmem_lsu_rmw.sv
// Load/store unit in front of a 64-bit word-indexed data memory: turns RV64 byte-addressed
// loads/stores into whole-doubleword accesses, read-modify-write for narrow stores.
module dmem_lsu_rmw #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned IDX_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [63:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic [63:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned LANES  = DATA_W / 8;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned WIDX_W = ADDR_W - 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_RESP
    } state_e;

    state_e              state_q, state_d;
    logic                write_q, write_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [2:0]          off_q, off_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   old_q, old_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;

    logic                req_misalign;
    logic                req_oor;
    logic                req_err;
    logic [DATA_W-1:0]   load_sh;
    logic                load_sign;
    logic [DATA_W-1:0]   load_ext;
    logic [LANES-1:0]    size_mask;
    logic [LANES-1:0]    lane_mask;
    logic [DATA_W-1:0]   wdata_sh;
    logic [DATA_W-1:0]   merged;

    // Request legality: size from funct3[1:0], offset must be size-aligned, index in range
    always_comb begin
        req_misalign = 1'b0;
        case (req_funct3[1:0])
            2'd0:    req_misalign = 1'b0;
            2'd1:    req_misalign = req_addr[0];
            2'd2:    req_misalign = |req_addr[1:0];
            default: req_misalign = |req_addr[2:0];
        endcase
        req_oor = req_addr[ADDR_W-1:3] >= WIDX_W'(DEPTH);
        req_err = (req_funct3 == 3'b111) | (req_write & req_funct3[2]) | req_misalign | req_oor;
    end

    // Load extraction: shift the addressed lane down, truncate, then sign/zero extend
    always_comb begin
        load_sh   = mem_rdata >> {off_q, 3'b000};
        load_sign = 1'b0;
        load_ext  = '0;
        case (funct3_q[1:0])
            2'd0: begin
                load_sign = load_sh[7] & ~funct3_q[2];
                load_ext  = {{(DATA_W-8){load_sign}}, load_sh[7:0]};
            end
            2'd1: begin
                load_sign = load_sh[15] & ~funct3_q[2];
                load_ext  = {{(DATA_W-16){load_sign}}, load_sh[15:0]};
            end
            2'd2: begin
                load_sign = load_sh[31] & ~funct3_q[2];
                load_ext  = {{(DATA_W-32){load_sign}}, load_sh[31:0]};
            end
            default: load_ext = load_sh;
        endcase
    end

    // Store merge: replace the addressed byte lanes of the old doubleword with new data
    always_comb begin
        case (funct3_q[1:0])
            2'd0:    size_mask = LANES'(8'h01);
            2'd1:    size_mask = LANES'(8'h03);
            2'd2:    size_mask = LANES'(8'h0F);
            default: size_mask = LANES'(8'hFF);
        endcase
        lane_mask = size_mask << off_q;
        wdata_sh  = wdata_q << {off_q, 3'b000};
        merged    = old_q;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (lane_mask[i]) begin
                merged[8*i +: 8] = wdata_sh[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            write_q      <= 1'b0;
            funct3_q     <= 3'b000;
            off_q        <= 3'b000;
            idx_q        <= '0;
            wdata_q      <= '0;
            old_q        <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            old_q        <= old_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        old_d        = old_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d      = req_write;
                    funct3_d     = req_funct3;
                    off_d        = req_addr[2:0];
                    // Index is only truncated once the range check has passed
                    idx_d        = req_err ? '0 : req_addr[IDX_W+2:3];
                    wdata_d      = req_wdata;
                    old_d        = '0;
                    resp_rdata_d = '0;
                    resp_err_d   = req_err;
                    if (req_err) begin
                        state_d = S_RESP;
                    end else if (req_write && (req_funct3[1:0] == 2'd3)) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                old_d = mem_rdata;
                if (write_q) begin
                    state_d = S_WRITE;
                end else begin
                    resp_rdata_d = load_ext;
                    state_d      = S_RESP;
                end
            end
            S_WRITE: state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake and memory strobes are pure decodes of the state flop, so reset kills them at once
    assign busy       = (state_q != S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign mem_we     = (state_q == S_WRITE);
    assign mem_addr   = (state_q != S_IDLE) ? ADDR_W'(idx_q) : '0;
    assign mem_wdata  = (state_q == S_WRITE) ? merged : '0;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule
